// File: rtl/clk_pkg.sv
// clk_pkg: sequencer state type and the 72 MHz enable ratios
package clk_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
  localparam int CPU_DIV_9M      = 8;
  localparam int PIX_DIV_6M      = 12;
  localparam int SND_DIV_4M      = 18;
  localparam int ADPCM_NUM_640K  = 2;
  localparam int ADPCM_DEN_640K  = 225;
endpackage

// File: rtl/cen_frac.sv
// cen_frac: fractional clock enable giving NUM single-cycle pulses every DEN cycles
module cen_frac #(
  parameter int NUM = 1,
  parameter int DEN = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  output logic cen
);
  localparam int AW = $clog2(DEN) + 1;
  localparam logic [AW-1:0] NUM_W = AW'(NUM);
  localparam logic [AW-1:0] DEN_W = AW'(DEN);
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  assign sum = acc + NUM_W;
  // clear preloads DEN-NUM so the first enabled cycle always produces a pulse
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (clr) begin
      acc <= DEN_W - NUM_W;
      cen <= 1'b0;
    end else begin
      acc <= (sum >= DEN_W) ? sum - DEN_W : sum;
      cen <= sum >= DEN_W;
    end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: PLL lock qualification, core reset sequencing and clk_sys enable generation
module clk_en_gen
  import clk_pkg::*;
#(
  parameter int CPU_DIV   = CPU_DIV_9M,
  parameter int PIX_DIV   = PIX_DIV_6M,
  parameter int SND_DIV   = SND_DIV_4M,
  parameter int ADPCM_NUM = ADPCM_NUM_640K,
  parameter int ADPCM_DEN = ADPCM_DEN_640K,
  parameter int LOCK_HOLD = 1024,
  parameter int RST_HOLD  = 256
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic pause,
  output logic core_reset_n,
  output logic cen_phi1,
  output logic cen_phi2,
  output logic cen_pix,
  output logic cen_snd,
  output logic cen_adpcm,
  output logic running
);
  localparam int CW = $clog2(CPU_DIV);
  localparam int LW = $clog2(LOCK_HOLD);
  localparam int RW = $clog2(RST_HOLD);
  state_t state, state_nxt;
  logic lock_s1, lock_s2;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic [RW-1:0] rst_cnt, rst_cnt_nxt;
  logic [CW-1:0] cpu_cnt;
  logic clr, gate, hold, snd_raw;
  // next state: qualify lock, hold reset in SETTLE, drop straight back on lock loss
  always_comb begin
    state_nxt = state;
    lock_cnt_nxt = '0;
    rst_cnt_nxt = '0;
    case (state)
      WAIT_LOCK: begin
        lock_cnt_nxt = lock_s2 ? lock_cnt + 1'b1 : '0;
        if (lock_s2 && lock_cnt == LW'(LOCK_HOLD - 1)) begin
          state_nxt = SETTLE;
          lock_cnt_nxt = '0;
        end
      end
      SETTLE: begin
        rst_cnt_nxt = rst_cnt + 1'b1;
        if (rst_cnt == RW'(RST_HOLD - 1)) begin
          state_nxt = RUN;
          rst_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
    if (state != WAIT_LOCK && !lock_s2) begin
      state_nxt = WAIT_LOCK;
      rst_cnt_nxt = '0;
    end
  end
  // lock synchroniser and sequencer registers
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      state <= WAIT_LOCK;
      lock_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
      state <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      rst_cnt <= rst_cnt_nxt;
    end
  assign clr = state_nxt == WAIT_LOCK;
  assign gate = pause && state_nxt == RUN;
  // phi counter keeps running through pause so the 68000 phase survives it
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      cpu_cnt <= '0;
      cen_phi1 <= 1'b0;
      cen_phi2 <= 1'b0;
      hold <= 1'b0;
      core_reset_n <= 1'b0;
      running <= 1'b0;
    end else begin
      cpu_cnt <= (clr || cpu_cnt == CW'(CPU_DIV - 1)) ? '0 : cpu_cnt + 1'b1;
      cen_phi1 <= !clr && !gate && cpu_cnt == '0;
      cen_phi2 <= !clr && !gate && cpu_cnt == CW'(CPU_DIV / 2);
      hold <= gate;
      core_reset_n <= state_nxt == RUN;
      running <= state_nxt == RUN;
    end
  assign cen_snd = snd_raw && !hold;
  cen_frac #(.NUM(1), .DEN(PIX_DIV)) u_pix (
    .clk_sys(clk_sys), .reset_n(reset_n), .clr(clr), .cen(cen_pix)
  );
  cen_frac #(.NUM(1), .DEN(SND_DIV)) u_snd (
    .clk_sys(clk_sys), .reset_n(reset_n), .clr(clr), .cen(snd_raw)
  );
  cen_frac #(.NUM(ADPCM_NUM), .DEN(ADPCM_DEN)) u_adpcm (
    .clk_sys(clk_sys), .reset_n(reset_n), .clr(clr), .cen(cen_adpcm)
  );
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: scoreboard bench for the clock enable generator
module tb_clk_en_gen;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic pll_locked = 1'b1;
  logic pause = 1'b0;
  logic core_reset_n, cen_phi1, cen_phi2, cen_pix, cen_snd, cen_adpcm, running;
  typedef struct packed { int t; logic [4:0] v; } ev_t;
  ev_t q_cen[$];
  ev_t q_lvl[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int w0 = -1;
  int cnt [5] = '{0, 0, 0, 0, 0};
  logic [4:0] cv;
  logic [1:0] lv;
  logic [1:0] lv_prev = 2'b00;

  clk_en_gen dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pll_locked(pll_locked), .pause(pause),
    .core_reset_n(core_reset_n), .cen_phi1(cen_phi1), .cen_phi2(cen_phi2),
    .cen_pix(cen_pix), .cen_snd(cen_snd), .cen_adpcm(cen_adpcm), .running(running)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk_sys);
  endtask

  // expected pulses on the enable grid anchored at s; phi/snd masked in [pa,pb]
  task automatic push_phase(input int s, input int last, input int pa, input int pb);
    ev_t e;
    int k;
    bit p;
    for (int t = s; t <= last; t++) begin
      k = t - s;
      p = t >= pa && t <= pb;
      e.t = t;
      e.v = {k % 8 == 0 && !p, k % 8 == 4 && !p, k % 12 == 0, k % 18 == 0 && !p,
             k % 225 == 0 || k % 225 == 113};
      if (e.v != 5'b0) q_cen.push_back(e);
    end
  endtask

  task automatic push_lvl(input int t, input logic [1:0] v);
    ev_t e;
    e.t = t;
    e.v = {3'b000, v};
    q_lvl.push_back(e);
  endtask

  always @(negedge clk_sys) begin
    cv = {cen_phi1, cen_phi2, cen_pix, cen_snd, cen_adpcm};
    lv = {core_reset_n, running};
    if (q_cen.size() > 0 && q_cen[0].t == cyc) begin
      total++;
      if (cv != q_cen[0].v) begin
        bad++;
        $display("FAIL cen t=%0d got=%b want=%b", cyc, cv, q_cen[0].v);
      end
      void'(q_cen.pop_front());
    end else if (cv != 5'b0) begin
      total++;
      bad++;
      $display("FAIL cen_unexpected t=%0d got=%b want=00000", cyc, cv);
    end
    if (lv != lv_prev) begin
      total++;
      if (q_lvl.size() > 0 && q_lvl[0].t == cyc && q_lvl[0].v == {3'b000, lv})
        void'(q_lvl.pop_front());
      else begin
        bad++;
        $display("FAIL level t=%0d got=%b want=%b@%0d", cyc, lv,
                 q_lvl.size() > 0 ? q_lvl[0].v[1:0] : 2'bxx,
                 q_lvl.size() > 0 ? q_lvl[0].t : -1);
      end
    end
    lv_prev = lv;
    if (w0 >= 0 && cyc >= w0 && cyc < w0 + 7200)
      for (int i = 0; i < 5; i++) cnt[i] += int'(cv[4-i]);
  end

  initial begin
    int s1, u1, pa, ld, p2, g, s2, x, r3, s3, u3, e;
    go_to(3);
    chk("reset_outputs", {core_reset_n, running, cen_phi1, cen_phi2, cen_pix, cen_snd, cen_adpcm}, 0);
    s1 = 3 + 1026;
    u1 = s1 + 256;
    pa = u1 + 7200 + 65;
    ld = pa + 150;
    push_phase(s1, ld + 1, pa, pa + 99);
    push_lvl(u1, 2'b11);
    push_lvl(ld + 2, 2'b00);
    w0 = u1;
    reset_n = 1'b1;
    go_to(u1 + 7200);
    chk("run_phi1_count", cnt[0], 900);
    chk("run_phi2_count", cnt[1], 900);
    chk("run_pix_count", cnt[2], 600);
    chk("run_snd_count", cnt[3], 400);
    chk("run_adpcm_count", cnt[4], 64);
    go_to(pa - 1);
    pause = 1'b1;
    go_to(pa + 99);
    pause = 1'b0;
    go_to(ld - 1);
    pll_locked = 1'b0;
    go_to(ld + 2);
    chk("lock_loss_outputs", {core_reset_n, running, cen_phi1, cen_phi2, cen_pix, cen_snd, cen_adpcm}, 0);
    p2 = ld + 10;
    go_to(p2 - 1);
    pll_locked = 1'b1;
    g = p2 + 1002;
    go_to(g - 1);
    pll_locked = 1'b0;
    go_to(g);
    pll_locked = 1'b1;
    s2 = g + 1 + 1025;
    x = s2 + 100;
    push_phase(s2, x - 1, -1, -1);
    go_to(x - 1);
    reset_n = 1'b0;
    go_to(x);
    chk("settle_reset_outputs", {core_reset_n, running, cen_phi1, cen_phi2, cen_pix, cen_snd, cen_adpcm}, 0);
    r3 = x + 4;
    go_to(r3);
    reset_n = 1'b1;
    s3 = r3 + 1026;
    u3 = s3 + 256;
    e = u3 + 300;
    push_phase(s3, e, -1, -1);
    push_lvl(u3, 2'b11);
    go_to(e + 1);
    chk("pending_pulses", q_cen.size(), 0);
    chk("pending_levels", q_lvl.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
